// File: rtl/song_step_sequencer.sv
// song_step_sequencer: tempo-paced walk over a song ROM that
// emits registered per-channel enable, waveform and pitch vectors.
module song_step_sequencer #(
  parameter int NUM_CHANNELS = 25,
  parameter int SONG_LENGTH  = 128,
  parameter int CLK_DIVIDE   = 1499999,
  parameter int ADDR_W       = $clog2(SONG_LENGTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  input  logic [95:0]                rom_data,
  output logic [ADDR_W-1:0]          rom_addr,
  output logic [NUM_CHANNELS-1:0]    channel_ena,
  output logic [2*NUM_CHANNELS-1:0]  waveforms,
  output logic [12*NUM_CHANNELS-1:0] pitches,
  output logic                       step_strobe
);

  localparam int DIV_W = $clog2(CLK_DIVIDE + 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DECODE,
    WAIT
  } state_t;

  state_t                      state;
  logic [DIV_W-1:0]            divider;
  logic                        end_mark;
  logic [NUM_CHANNELS-1:0]     nxt_ena;
  logic [2*NUM_CHANNELS-1:0]   nxt_wave;
  logic [12*NUM_CHANNELS-1:0]  nxt_pitch;

  // Later slots win because they are visited last for each channel.
  always_comb begin
    nxt_ena   = '0;
    nxt_wave  = '0;
    nxt_pitch = '0;
    end_mark  = rom_data[23] && (rom_data[20:16] == 5'd31);
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      for (int s = 0; s < 4; s++) begin
        if (!end_mark && c != 31 &&
            rom_data[24*s+23] &&
            rom_data[24*s+16 +: 5] == 5'(c)) begin
          nxt_ena[c]          = 1'b1;
          nxt_wave[2*c +: 2]  = rom_data[24*s+21 +: 2];
          nxt_pitch[12*c +: 12] = rom_data[24*s +: 12];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      rom_addr    <= '0;
      divider     <= '0;
      channel_ena <= '0;
      waveforms   <= '0;
      pitches     <= '0;
      step_strobe <= 1'b0;
    end else begin
      step_strobe <= 1'b0;
      if (!ena) begin
        state       <= IDLE;
        rom_addr    <= '0;
        divider     <= '0;
        channel_ena <= '0;
        waveforms   <= '0;
        pitches     <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            state <= FETCH;
          end
          FETCH: begin
            state <= DECODE;
          end
          DECODE: begin
            channel_ena <= nxt_ena;
            waveforms   <= nxt_wave;
            pitches     <= nxt_pitch;
            step_strobe <= 1'b1;
            divider     <= '0;
            state       <= WAIT;
            if (end_mark ||
                rom_addr == ADDR_W'(SONG_LENGTH - 1))
              rom_addr <= '0;
            else
              rom_addr <= rom_addr + 1'b1;
          end
          WAIT: begin
            divider <= divider + 1'b1;
            if (divider == DIV_W'(CLK_DIVIDE - 2))
              state <= FETCH;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_song_step_sequencer.sv
// tb_song_step_sequencer: directed and random playback against
// a slot-by-slot note model and an arithmetic step-timing model.
module tb_song_step_sequencer;

  localparam int NC = 25;
  localparam int SL = 4;
  localparam int CD = 9;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ena = 1'b0;
  logic [95:0] rom_data = '0;
  logic [AW-1:0] rom_addr;
  logic [NC-1:0] channel_ena;
  logic [2*NC-1:0] waveforms;
  logic [12*NC-1:0] pitches;
  logic step_strobe;

  logic [95:0] rom [SL];
  int checks = 0;
  int errors = 0;
  int exp_addr = 0;

  song_step_sequencer #(
    .NUM_CHANNELS(NC),
    .SONG_LENGTH (SL),
    .CLK_DIVIDE  (CD),
    .ADDR_W      (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .rom_data   (rom_data),
    .rom_addr   (rom_addr),
    .channel_ena(channel_ena),
    .waveforms  (waveforms),
    .pitches    (pitches),
    .step_strobe(step_strobe)
  );

  always #5 clk = ~clk;

  // one-cycle-latency ROM
  always @(posedge clk) rom_data <= rom[rom_addr];

  function automatic logic [23:0] slot(input bit v, input int wf,
                                       input int ch, input int p);
    return {v, 2'(wf), 5'(ch), 4'h0, 12'(p)};
  endfunction

  function automatic bit is_end(input logic [95:0] w);
    return w[23] && (w[20:16] == 5'd31);
  endfunction

  function automatic void model(input logic [95:0] w,
                                output logic [NC-1:0] e,
                                output logic [2*NC-1:0] wv,
                                output logic [12*NC-1:0] p);
    bit on [NC];
    int wfa [NC];
    int pa [NC];
    for (int c = 0; c < NC; c++) begin
      on[c] = 0;
      wfa[c] = 0;
      pa[c] = 0;
    end
    if (!is_end(w)) begin
      for (int s = 0; s < 4; s++) begin
        logic [23:0] f;
        int ch;
        f = w[24*s +: 24];
        ch = int'(f[20:16]);
        if (f[23] && ch < NC) begin
          on[ch] = 1;
          wfa[ch] = int'(f[22:21]);
          pa[ch] = int'(f[11:0]);
        end
      end
    end
    e = '0;
    wv = '0;
    p = '0;
    for (int c = 0; c < NC; c++) begin
      e[c] = on[c];
      wv[2*c +: 2] = 2'(wfa[c]);
      p[12*c +: 12] = 12'(pa[c]);
    end
  endfunction

  function automatic logic [95:0] rand_word();
    logic [95:0] w;
    for (int s = 0; s < 4; s++) begin
      int ch;
      ch = ($urandom & 1) ? $urandom_range(0, 3) : $urandom_range(0, 31);
      w[24*s +: 24] = {1'($urandom_range(0, 3) != 0), 2'($urandom),
                       5'(ch), 4'($urandom), 12'($urandom)};
    end
    return w;
  endfunction

  task automatic chk(input string tag, input logic [299:0] obs,
                     input logic [299:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic zeros(input string tag);
    chk({tag, "_ena"}, channel_ena, 0);
    chk({tag, "_wave"}, waveforms, 0);
    chk({tag, "_pitch"}, pitches, 0);
    chk({tag, "_strobe"}, step_strobe, 0);
    chk({tag, "_addr"}, rom_addr, 0);
  endtask

  // wait for the next strobe (bounded) and check gap, notes, next address
  task automatic step(input int gap, input string tag);
    int n;
    logic [NC-1:0] e;
    logic [2*NC-1:0] wv;
    logic [12*NC-1:0] p;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!step_strobe && n < 40);
    chk({tag, "_gap"}, n, gap);
    model(rom[exp_addr], e, wv, p);
    chk({tag, "_ena"}, channel_ena, e);
    chk({tag, "_wave"}, waveforms, wv);
    chk({tag, "_pitch"}, pitches, p);
    exp_addr = is_end(rom[exp_addr]) ? 0 : (exp_addr + 1) % SL;
    chk({tag, "_addr"}, rom_addr, exp_addr);
  endtask

  initial begin
    rom[0] = {24'h0, 24'h0, slot(1, 3, 1, 106), slot(1, 1, 0, 212)};
    rom[1] = {slot(1, 2, 27, 77), slot(1, 1, 5, 200),
              slot(1, 2, 5, 100), slot(1, 0, 7, 333)};
    rom[2] = {slot(1, 1, 3, 55), 24'h0, 24'h0, slot(1, 0, 31, 0)};
    rom[3] = {24'h0, 24'h0, slot(1, 1, 25, 9), slot(1, 3, 24, 4095)};

    #12;
    zeros("reset");
    ena = 1'b1;
    @(negedge clk);
    rst = 1'b1;

    step(3, "s0");
    chk("d_ena", channel_ena[1:0], 2'b11);
    chk("d_p0", pitches[11:0], 212);
    chk("d_p1", pitches[23:12], 106);
    chk("d_wf", waveforms[3:0], 4'b1101);
    step(10, "s1");
    chk("c_p5", pitches[71:60], 200);
    chk("c_wf5", waveforms[11:10], 1);
    chk("c_ena", channel_ena, 25'h0A0);
    step(10, "s2_end");
    chk("e_rest", channel_ena, 0);
    chk("e_addr", rom_addr, 0);
    step(10, "s3");
    step(10, "s4");

    // async reset mid-wait while notes are sounding
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1 zeros("async_rst");
    rom[2] = {24'h0, slot(1, 3, 11, 7), 24'h0, slot(1, 2, 10, 1000)};
    rom[3] = rand_word();
    rom[3][23] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_addr = 0;
    step(3, "r0");
    step(10, "r1");
    step(10, "r2");

    // stop while address 3 is being fetched
    repeat (8) @(posedge clk);
    #1;
    chk("fetch_addr", rom_addr, 3);
    ena = 1'b0;
    @(posedge clk);
    #1;
    zeros("stop");
    ena = 1'b1;
    exp_addr = 0;
    step(3, "rew");
    chk("rew_p0", pitches[11:0], 212);

    for (int r = 0; r < 6; r++) begin
      ena = 1'b0;
      @(posedge clk);
      #1;
      zeros("clr");
      for (int a = 0; a < SL; a++) rom[a] = rand_word();
      @(negedge clk);
      ena = 1'b1;
      exp_addr = 0;
      step(3, "rnd_first");
      for (int k = 0; k < 7; k++) step(10, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
